imem_boot_ctrl: RTL and testbench

Boot-time program loader and sequencer for the byte-addressed, big-endian instruction memory (256 × 8-bit). After reset it holds the pipeline stalled, accepts a program as a byte stream over a valid/ready handshake, and writes each byte into the instruction memory's write port. It validates the requested length and keeps an 8-bit running checksum, then releases the CPU once the full image is resident. It sits between the host/testbench byte source, the instruction memory write port and the pipeline's global stall.

---
 rtl/imem_boot_ctrl.sv | 113 +++++++++++
 tb/tb_imem_boot_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot-time program loader: streams a byte image into instruction memory over valid/ready,
// validates the length, keeps a running checksum and stalls the CPU until the image is resident.
module imem_boot_ctrl #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W:0]   Len,
    input  logic              Abort,
    input  logic              In_Valid,
    input  logic [7:0]        In_Data,
    output logic              In_Ready,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_WAddr,
    output logic [7:0]        Mem_WData,
    output logic              Cpu_Stall,
    output logic              Done,
    output logic              Error,
    output logic [7:0]        Checksum
);

    localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

    state_e          state_q;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] count_q;
    logic [7:0]      sum_q;
    logic            ready_q;
    logic            stall_q;
    logic            done_q;
    logic            error_q;

    logic len_ok;
    logic accept;
    logic last;

    // Only whole 32-bit instructions that fit in memory are accepted.
    assign len_ok = (Len != '0) && (Len[1:0] == 2'b00) && (Len <= DepthLen);
    assign accept = (state_q == StLoad) && In_Valid && !Abort;
    assign last   = (count_q == len_q - 1'b1);

    assign Mem_We    = accept;
    assign Mem_WAddr = accept ? count_q[ADDR_W-1:0] : '0;
    assign Mem_WData = accept ? In_Data : '0;
    assign In_Ready  = ready_q;
    assign Cpu_Stall = stall_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign Checksum  = sum_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            ready_q <= 1'b0;
            stall_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (Start) begin
                        stall_q <= 1'b1;
                        done_q  <= 1'b0;
                        if (len_ok) begin
                            state_q <= StLoad;
                            len_q   <= Len;
                            count_q <= '0;
                            sum_q   <= '0;
                            ready_q <= 1'b1;
                            error_q <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            ready_q <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    // Abort wins over a byte offered in the same cycle; partial sum is kept.
                    if (Abort) begin
                        state_q <= StIdle;
                        count_q <= '0;
                        ready_q <= 1'b0;
                    end else if (In_Valid) begin
                        count_q <= count_q + 1'b1;
                        sum_q   <= sum_q + In_Data;
                        if (last) begin
                            state_q <= StDone;
                            ready_q <= 1'b0;
                            stall_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    stall_q <= 1'b1;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: a driver pushes expected outputs from a length/count
// model into queues; a negedge monitor pops and compares what the loader presents.
module tb_imem_boot_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Start;
    logic [8:0] Len;
    logic       Abort;
    logic       In_Valid;
    logic [7:0] In_Data;
    logic       In_Ready;
    logic       Mem_We;
    logic [7:0] Mem_WAddr;
    logic [7:0] Mem_WData;
    logic       Cpu_Stall;
    logic       Done;
    logic       Error;
    logic [7:0] Checksum;

    imem_boot_ctrl #(.DEPTH(256), .ADDR_W(8)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Len       (Len),
        .Abort     (Abort),
        .In_Valid  (In_Valid),
        .In_Data   (In_Data),
        .In_Ready  (In_Ready),
        .Mem_We    (Mem_We),
        .Mem_WAddr (Mem_WAddr),
        .Mem_WData (Mem_WData),
        .Cpu_Stall (Cpu_Stall),
        .Done      (Done),
        .Error     (Error),
        .Checksum  (Checksum)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       ready;
        logic       stall;
        logic       done;
        logic       error;
        logic [7:0] sum;
    } exp_t;

    exp_t        st_q[$];
    logic [15:0] wr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam int MIdle = 0, MLoad = 1, MDone = 2, MErr = 3;
    int m_mode, m_cnt, m_len, m_sum;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MIdle;
        m_cnt  = 0;
        m_len  = 0;
        m_sum  = 0;
    endtask

    // Next-state of the reference model for one clock edge.
    task automatic model_edge(input logic st, input int ln, input logic ab, input logic v,
                              input logic [7:0] d);
        if (m_mode == MLoad) begin
            if (ab) begin
                m_mode = MIdle;
                m_cnt  = 0;
            end else if (v) begin
                m_cnt++;
                m_sum = (m_sum + int'(d)) % 256;
                if (m_cnt == m_len) m_mode = MDone;
            end
        end else if (st) begin
            if (ln != 0 && ln % 4 == 0 && ln <= 256) begin
                m_mode = MLoad;
                m_len  = ln;
                m_cnt  = 0;
                m_sum  = 0;
            end else begin
                m_mode = MErr;
            end
        end
    endtask

    task automatic step(input logic st, input int ln, input logic ab, input logic v,
                        input logic [7:0] d, input logic rst);
        exp_t e;
        int   l9;
        l9 = ln & 511;
        @(posedge Clk);
        #1;
        Rst_n    = rst;
        Start    = st;
        Len      = 9'(l9);
        Abort    = ab;
        In_Valid = v;
        In_Data  = d;
        if (!rst) model_reset();
        e.we    = (m_mode == MLoad) && v && !ab;
        e.addr  = e.we ? 8'(m_cnt % 256) : 8'h00;
        e.data  = e.we ? d : 8'h00;
        e.ready = (m_mode == MLoad);
        e.stall = (m_mode != MDone);
        e.done  = (m_mode == MDone);
        e.error = (m_mode == MErr);
        e.sum   = 8'(m_sum);
        st_q.push_back(e);
        if (e.we) wr_q.push_back({e.addr, e.data});
        if (rst) model_edge(st, l9, ab, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic start(input int ln);
        step(1'b1, ln, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic feed(input logic [7:0] d);
        step(1'b0, 0, 1'b0, 1'b1, d, 1'b1);
    endtask

    exp_t        me;
    logic [15:0] mw;

    always @(negedge Clk) begin
        if (st_q.size() > 0) begin
            me = st_q.pop_front();
            chk("mem_we", Mem_We, me.we);
            chk("in_ready", In_Ready, me.ready);
            chk("cpu_stall", Cpu_Stall, me.stall);
            chk("done", Done, me.done);
            chk("error", Error, me.error);
            chk("checksum", Checksum, me.sum);
            chk("waddr_idle", Mem_We ? 8'h00 : Mem_WAddr, 8'h00);
            chk("wdata_idle", Mem_We ? 8'h00 : Mem_WData, 8'h00);
        end
        if (Mem_We === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_extra: got write addr %0h expected no write at %0t",
                         Mem_WAddr, $time);
            end else begin
                mw = wr_q.pop_front();
                chk("wr_addr", Mem_WAddr, mw[15:8]);
                chk("wr_data", Mem_WData, mw[7:0]);
            end
        end
    end

    logic [7:0] img[8];
    logic [7:0] b;
    int         part;

    initial begin
        img[0] = 8'h20; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h05;
        img[4] = 8'h00; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h00;
        Rst_n = 1'b0; Start = 1'b0; Len = '0; Abort = 1'b0; In_Valid = 1'b0; In_Data = '0;
        model_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(2);

        // Directed image, back to back.
        start(8);
        for (int i = 0; i < 8; i++) feed(img[i]);
        idle(1);
        @(negedge Clk);
        chk("img_checksum", Checksum, 8'h2D);
        chk("img_done", Done, 1'b1);
        chk("img_stall", Cpu_Stall, 1'b0);

        // Gapped valid.
        start(8);
        for (int i = 0; i < 16; i++) step(1'b0, 0, 1'b0, i % 2 == 0, 8'($urandom), 1'b1);
        idle(1);

        // Illegal lengths, then a legal one.
        start(6);   idle(1);
        start(0);   idle(1);
        start(260); idle(1);
        start(4);
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        idle(2);

        // Full memory.
        start(256);
        for (int i = 0; i < 256; i++) feed(8'h01);
        idle(2);
        @(negedge Clk);
        chk("full_checksum", Checksum, 8'h00);

        // Abort after three bytes, with a byte offered on the abort cycle.
        start(16);
        part = 0;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            part = (part + int'(b)) % 256;
            feed(b);
        end
        step(1'b0, 0, 1'b1, 1'b1, 8'hAA, 1'b1);
        idle(1);
        @(negedge Clk);
        chk("abort_checksum", Checksum, 8'(part));
        chk("abort_stall", Cpu_Stall, 1'b1);

        // Reset pulse mid-load.
        start(8);
        feed(8'h11);
        feed(8'h22);
        step(1'b0, 0, 1'b0, 1'b1, 8'h33, 1'b0);
        @(negedge Clk);
        chk("rst_checksum", Checksum, 8'h00);
        chk("rst_ready", In_Ready, 1'b0);
        idle(2);

        // Reload straight from DONE.
        start(4);
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        start(4);
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        idle(2);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int ln;
            if ($urandom_range(0, 9) < 7) ln = 4 * int'($urandom_range(1, 16));
            else ln = int'($urandom_range(0, 300));
            step($urandom_range(0, 19) == 0, ln, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0, 8'($urandom), 1'b1);
        end
        idle(2);

        @(negedge Clk);
        #1;
        chk("status_queue_drained", st_q.size(), 0);
        chk("write_queue_drained", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
